mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage in-order pipeline; sits between the execute stage and the write-back stage.
- Takes the execute-stage payload and the synchronous data-SRAM read data for loads issued during execute.
- Extracts, aligns and sign/zero-extends load data, then selects the final register write value.
- Drives write-back, and exposes destination and valid information to decode for load-use and bypass checks.

Parameters:
PC_RST, 32'h0000_0000, reset value of ms_pc

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
es_to_ms_valid  in  1  execute has a valid instruction for MEM
ms_allowin  out  1  MEM can accept an instruction this cycle
es_pc  in  32  instruction PC
es_rf_we  in  1  register write enable
es_rf_waddr  in  5  destination register
es_alu_result  in  32  ALU result / memory address
es_res_from_mem  in  1  instruction is a load
es_ld_inst  in  5  one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu} (bit4..bit0)
data_sram_rdata  in  32  SRAM read data, valid the cycle after the request
ws_allowin  in  1  write-back can accept
ms_to_ws_valid  out  1  valid instruction for write-back
ms_pc  out  32  PC of the instruction in MEM
ms_rf_we  out  1  register write enable, gated by ms_valid
ms_rf_waddr  out  5  destination register
ms_rf_wdata  out  32  final register write data
ms_res_from_mem  out  1  MEM holds a valid load (for decode hazard checks)

Behaviour:
- Reset: synchronous, active-low; clock clk.
  - Reset clears ms_valid, rdata hold flag, rf_we, res_from_mem, ld_inst, waddr and alu_result.
  - ms_pc resets to PC_RST.
  - Reset outputs: ms_to_ws_valid=0, ms_rf_we=0, ms_rf_waddr=0, ms_rf_wdata=0, ms_res_from_mem=0, ms_allowin=1.
  - Reset mid-operation discards the in-flight instruction and any held data.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
  - When ms_allowin, ms_valid <= es_to_ms_valid.
  - Payload registers load on es_to_ms_valid && ms_allowin and hold otherwise.
- Latency: one cycle per instruction; no internal stall source.
- Load data hold (mandatory):
  - SRAM data is valid only in the first MEM cycle of a load.
  - On that cycle, if !ws_allowin, capture data_sram_rdata into rdata_buf and set buf_vld.
  - ld_word = buf_vld ? rdata_buf : data_sram_rdata.
  - buf_vld clears when the instruction leaves (ms_valid && ws_allowin) or on reset.
  - A new instruction can never observe a stale buffer.
- Alignment: addr = alu_result[1:0].
  - ld_b / ld_bu: byte addr selects ld_word[8*addr+7 : 8*addr], sign- or zero-extended.
  - ld_h / ld_hu: addr[1] selects the upper or lower halfword, sign- or zero-extended; addr[0] ignored.
  - ld_w: ld_word unchanged.
- Output data: ms_rf_wdata = ms_res_from_mem_reg ? ld_result : alu_result.
- Gating: ms_rf_we = ms_valid && rf_we_reg; ms_res_from_mem = ms_valid && res_from_mem_reg.
- Simultaneous events: instruction leaving while a new one enters in the same cycle: buffer clears; the new load samples the fresh SRAM data next cycle.

Optional Feature:
MEM_ALE_CHECK_EN
- Defined: adds output ms_ale (1 bit).
  - ms_ale = ms_valid && ((ld_w && addr!=0) || ((ld_h||ld_hu) && addr[0])).
  - When ms_ale=1, ms_rf_we is forced to 0.
- Undefined: no ms_ale port; misaligned loads use the alignment rules above and write normally.

Test Plan:
- ld_b, addr 0x1003, rdata 0x80FF_1234, ws_allowin=1 -> next-cycle ms_rf_wdata=0xFFFF_FF80, ms_rf_we=1.
- ld_hu, addr 0x2002, rdata 0x8001_7FFF -> wdata 0x0000_8001; ld_h same inputs -> 0xFFFF_8001.
- ld_w with ws_allowin=0 for 3 cycles; rdata 0xDEAD_BEEF on the first cycle, then 0x0 -> wdata stays 0xDEAD_BEEF, ms_allowin=0 throughout, accepted when ws_allowin=1.
- Back-to-back add (alu_result 0x5) then ld_bu (rdata byte 0xAB) with no stall -> wdata 0x5 then 0x0000_00AB; ms_to_ws_valid high both cycles.
- Bubble (es_to_ms_valid=0) after a valid instruction -> ms_to_ws_valid=0, ms_rf_we=0, ms_res_from_mem=0.
- resetn=0 while a stalled load is held -> all outputs at reset values next cycle; buffer clear; with MEM_ALE_CHECK_EN, ld_w addr 0x2 -> ms_ale=1, ms_rf_we=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute-to-MEM payload and MEM-to-write-back signals; MEM_ALE_CHECK_EN adds ms_ale
interface mem_stage_if;
   logic        es_to_ms_valid;
   logic        ms_allowin;
   logic [31:0] es_pc;
   logic        es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_alu_result;
   logic        es_res_from_mem;
   logic [4:0]  es_ld_inst;
   logic [31:0] data_sram_rdata;
   logic        ws_allowin;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic        ms_res_from_mem;
`ifdef MEM_ALE_CHECK_EN
   logic        ms_ale;
`endif

   // Upstream/downstream side: drives execute payload, SRAM data and back-pressure.
   modport master (
      output es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr, es_alu_result,
             es_res_from_mem, es_ld_inst, data_sram_rdata, ws_allowin,
      input  ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
             ms_rf_wdata, ms_res_from_mem
`ifdef MEM_ALE_CHECK_EN
      , input ms_ale
`endif
   );

   // Memory stage view.
   modport slave (
      input  es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr, es_alu_result,
             es_res_from_mem, es_ld_inst, data_sram_rdata, ws_allowin,
      output ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
             ms_rf_wdata, ms_res_from_mem
`ifdef MEM_ALE_CHECK_EN
      , output ms_ale
`endif
   );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: load data hold, alignment, extension; MEM_ALE_CHECK_EN adds misalignment flag
module mem_stage #(
   parameter logic [31:0] PC_RST = 32'h0000_0000
) (
   input  logic      clk,
   input  logic      resetn,
   mem_stage_if.slave bus
);
   // one-hot load type bit positions
   localparam int LD_B  = 4;
   localparam int LD_H  = 3;
   localparam int LD_W  = 2;
   localparam int LD_BU = 1;
   localparam int LD_HU = 0;

   logic        ms_valid;
   logic        ms_allowin;
   logic [31:0] pc_reg;
   logic        rf_we_reg;
   logic [4:0]  rf_waddr_reg;
   logic [31:0] alu_result_reg;
   logic        res_from_mem_reg;
   logic [4:0]  ld_inst_reg;
   logic [31:0] rdata_buf;
   logic        buf_vld;
   logic [31:0] ld_word;
   logic [1:0]  addr;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_result;
   logic        ale;

   // MEM never stalls on its own, so it frees up whenever write-back takes the current instruction
   assign ms_allowin = !ms_valid || bus.ws_allowin;

   // valid bit advances only when the stage can accept
   always_ff @(posedge clk) begin
      if (!resetn)
         ms_valid <= 1'b0;
      else if (ms_allowin)
         ms_valid <= bus.es_to_ms_valid;
   end

   // capture execute payload on an accepted handshake, hold otherwise
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_reg           <= PC_RST;
         rf_we_reg        <= 1'b0;
         rf_waddr_reg     <= 5'd0;
         alu_result_reg   <= 32'd0;
         res_from_mem_reg <= 1'b0;
         ld_inst_reg      <= 5'd0;
      end else if (bus.es_to_ms_valid && ms_allowin) begin
         pc_reg           <= bus.es_pc;
         rf_we_reg        <= bus.es_rf_we;
         rf_waddr_reg     <= bus.es_rf_waddr;
         alu_result_reg   <= bus.es_alu_result;
         res_from_mem_reg <= bus.es_res_from_mem;
         ld_inst_reg      <= bus.es_ld_inst;
      end
   end

   // SRAM data is only valid in the first MEM cycle; keep it while write-back stalls.
   // Clearing on departure takes priority so an incoming instruction never sees old data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         buf_vld   <= 1'b0;
         rdata_buf <= 32'd0;
      end else if (ms_valid && bus.ws_allowin) begin
         buf_vld   <= 1'b0;
      end else if (ms_valid && res_from_mem_reg && !buf_vld) begin
         buf_vld   <= 1'b1;
         rdata_buf <= bus.data_sram_rdata;
      end
   end

   assign ld_word = buf_vld ? rdata_buf : bus.data_sram_rdata;
   assign addr    = alu_result_reg[1:0];

   // pick the addressed byte/halfword and extend according to the load type
   always_comb begin
      ld_byte   = 8'd0;
      ld_result = ld_word;
      case (addr)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = addr[1] ? ld_word[31:16] : ld_word[15:0];
      if (ld_inst_reg[LD_B])
         ld_result = {{24{ld_byte[7]}}, ld_byte};
      else if (ld_inst_reg[LD_BU])
         ld_result = {24'd0, ld_byte};
      else if (ld_inst_reg[LD_H])
         ld_result = {{16{ld_half[15]}}, ld_half};
      else if (ld_inst_reg[LD_HU])
         ld_result = {16'd0, ld_half};
   end

`ifdef MEM_ALE_CHECK_EN
   assign ale = ms_valid && ((ld_inst_reg[LD_W] && (addr != 2'd0)) ||
                             ((ld_inst_reg[LD_H] || ld_inst_reg[LD_HU]) && addr[0]));
   assign bus.ms_ale = ale;
`else
   assign ale = 1'b0;
`endif

   assign bus.ms_allowin      = ms_allowin;
   assign bus.ms_to_ws_valid  = ms_valid;
   assign bus.ms_pc           = pc_reg;
   assign bus.ms_rf_we        = ms_valid && rf_we_reg && !ale;
   assign bus.ms_rf_waddr     = rf_waddr_reg;
   assign bus.ms_rf_wdata     = res_from_mem_reg ? ld_result : alu_result_reg;
   assign bus.ms_res_from_mem = ms_valid && res_from_mem_reg;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;
   localparam logic [4:0] LD_B  = 5'b10000;
   localparam logic [4:0] LD_H  = 5'b01000;
   localparam logic [4:0] LD_W  = 5'b00100;
   localparam logic [4:0] LD_BU = 5'b00010;
   localparam logic [4:0] LD_HU = 5'b00001;

   typedef struct {
      logic [4:0]  ld_inst;
      logic        res_mem;
      logic        rf_we;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] rdata;
      logic [31:0] exp_wdata;
   } vec_t;

   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   passed = 0;
   vec_t vecs[10];

   mem_stage_if bus();

   mem_stage dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      else
         passed++;
   endtask

   task automatic issue(input logic [4:0] ld, input logic res_mem, input logic we,
                        input logic [31:0] pc, input logic [31:0] a, input logic [4:0] waddr);
      bus.es_to_ms_valid  = 1'b1;
      bus.es_ld_inst      = ld;
      bus.es_res_from_mem = res_mem;
      bus.es_rf_we        = we;
      bus.es_pc           = pc;
      bus.es_alu_result   = a;
      bus.es_rf_waddr     = waddr;
   endtask

   initial begin
      vecs[0] = '{LD_B,  1'b1, 1'b1, 32'h100, 32'h1003, 32'h80FF_1234, 32'hFFFF_FF80};
      vecs[1] = '{LD_HU, 1'b1, 1'b1, 32'h104, 32'h2002, 32'h8001_7FFF, 32'h0000_8001};
      vecs[2] = '{LD_H,  1'b1, 1'b1, 32'h108, 32'h2002, 32'h8001_7FFF, 32'hFFFF_8001};
      vecs[3] = '{5'd0,  1'b0, 1'b1, 32'h10C, 32'h0000_0005, 32'h1234_5678, 32'h0000_0005};
      vecs[4] = '{LD_BU, 1'b1, 1'b1, 32'h110, 32'h0000_0041, 32'h1234_AB00, 32'h0000_00AB};
      vecs[5] = '{LD_B,  1'b1, 1'b1, 32'h114, 32'h0000_0040, 32'hFFFF_FF7F, 32'h0000_007F};
      vecs[6] = '{LD_H,  1'b1, 1'b1, 32'h118, 32'h0000_0080, 32'h0000_8000, 32'hFFFF_8000};
      vecs[7] = '{LD_W,  1'b1, 1'b1, 32'h11C, 32'h0000_0100, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[8] = '{LD_BU, 1'b1, 1'b1, 32'h120, 32'h0000_0202, 32'h00FF_0000, 32'h0000_00FF};
      vecs[9] = '{5'd0,  1'b0, 1'b0, 32'h124, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0040};

      resetn = 1'b0;
      bus.es_to_ms_valid  = 1'b0;
      bus.es_ld_inst      = 5'd0;
      bus.es_res_from_mem = 1'b0;
      bus.es_rf_we        = 1'b0;
      bus.es_pc           = 32'd0;
      bus.es_alu_result   = 32'd0;
      bus.es_rf_waddr     = 5'd0;
      bus.data_sram_rdata = 32'd0;
      bus.ws_allowin      = 1'b1;
      step();
      step();
      check("rst_valid", {31'd0, bus.ms_to_ws_valid}, 32'd0);
      check("rst_we", {31'd0, bus.ms_rf_we}, 32'd0);
      check("rst_waddr", {27'd0, bus.ms_rf_waddr}, 32'd0);
      check("rst_wdata", bus.ms_rf_wdata, 32'd0);
      check("rst_resmem", {31'd0, bus.ms_res_from_mem}, 32'd0);
      check("rst_allowin", {31'd0, bus.ms_allowin}, 32'd1);
      check("rst_pc", bus.ms_pc, 32'd0);
      resetn = 1'b1;
      step();

      // single-cycle instructions, write-back always ready
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].ld_inst, vecs[i].res_mem, vecs[i].rf_we, vecs[i].pc, vecs[i].addr, 5'(i + 1));
         step();
         bus.es_to_ms_valid  = 1'b0;
         bus.data_sram_rdata = vecs[i].rdata;
         #1;
         check($sformatf("v%0d_wdata", i), bus.ms_rf_wdata, vecs[i].exp_wdata);
         check($sformatf("v%0d_we", i), {31'd0, bus.ms_rf_we}, {31'd0, vecs[i].rf_we});
         check($sformatf("v%0d_valid", i), {31'd0, bus.ms_to_ws_valid}, 32'd1);
         check($sformatf("v%0d_resmem", i), {31'd0, bus.ms_res_from_mem}, {31'd0, vecs[i].res_mem});
         check($sformatf("v%0d_pc", i), bus.ms_pc, vecs[i].pc);
         check($sformatf("v%0d_waddr", i), {27'd0, bus.ms_rf_waddr}, 32'(i + 1));
         step();
      end

      // back-to-back add then ld_bu
      issue(5'd0, 1'b0, 1'b1, 32'h200, 32'h5, 5'd3);
      step();
      issue(LD_BU, 1'b1, 1'b1, 32'h204, 32'h0000_0301, 5'd4);
      #1;
      check("b2b_add_wdata", bus.ms_rf_wdata, 32'h5);
      check("b2b_add_valid", {31'd0, bus.ms_to_ws_valid}, 32'd1);
      step();
      bus.es_to_ms_valid  = 1'b0;
      bus.data_sram_rdata = 32'h0000_AB00;
      #1;
      check("b2b_ld_wdata", bus.ms_rf_wdata, 32'h0000_00AB);
      check("b2b_ld_valid", {31'd0, bus.ms_to_ws_valid}, 32'd1);
      step();

      // ld_w stalled three cycles, SRAM data gone after the first
      issue(LD_W, 1'b1, 1'b1, 32'h300, 32'h3000, 5'd5);
      step();
      bus.es_to_ms_valid  = 1'b0;
      bus.ws_allowin      = 1'b0;
      bus.data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      check("stall0_wdata", bus.ms_rf_wdata, 32'hDEAD_BEEF);
      check("stall0_allowin", {31'd0, bus.ms_allowin}, 32'd0);
      step();
      bus.data_sram_rdata = 32'h0;
      #1;
      check("stall1_wdata", bus.ms_rf_wdata, 32'hDEAD_BEEF);
      check("stall1_allowin", {31'd0, bus.ms_allowin}, 32'd0);
      step();
      check("stall2_wdata", bus.ms_rf_wdata, 32'hDEAD_BEEF);
      check("stall2_allowin", {31'd0, bus.ms_allowin}, 32'd0);
      bus.ws_allowin = 1'b1;
      #1;
      check("stall_rel_wdata", bus.ms_rf_wdata, 32'hDEAD_BEEF);
      check("stall_rel_allowin", {31'd0, bus.ms_allowin}, 32'd1);
      check("stall_rel_we", {31'd0, bus.ms_rf_we}, 32'd1);
      step();
      // bubble after the load
      check("bubble_valid", {31'd0, bus.ms_to_ws_valid}, 32'd0);
      check("bubble_we", {31'd0, bus.ms_rf_we}, 32'd0);
      check("bubble_resmem", {31'd0, bus.ms_res_from_mem}, 32'd0);

      // held load leaves while a new load enters the same cycle
      issue(LD_W, 1'b1, 1'b1, 32'h400, 32'h10, 5'd6);
      step();
      bus.es_to_ms_valid  = 1'b0;
      bus.ws_allowin      = 1'b0;
      bus.data_sram_rdata = 32'h1111_1111;
      step();
      bus.data_sram_rdata = 32'h0;
      issue(LD_W, 1'b1, 1'b1, 32'h404, 32'h20, 5'd7);
      bus.ws_allowin = 1'b1;
      #1;
      check("swap_old_wdata", bus.ms_rf_wdata, 32'h1111_1111);
      step();
      bus.es_to_ms_valid  = 1'b0;
      bus.data_sram_rdata = 32'h2222_2222;
      #1;
      check("swap_new_wdata", bus.ms_rf_wdata, 32'h2222_2222);
      check("swap_new_pc", bus.ms_pc, 32'h404);
      step();

      // reset while a stalled load holds buffered data
      issue(LD_B, 1'b1, 1'b1, 32'h500, 32'h1, 5'd8);
      step();
      bus.es_to_ms_valid  = 1'b0;
      bus.ws_allowin      = 1'b0;
      bus.data_sram_rdata = 32'hA5A5_5AA5;
      step();
      bus.data_sram_rdata = 32'h0;
      resetn = 1'b0;
      step();
      check("mrst_valid", {31'd0, bus.ms_to_ws_valid}, 32'd0);
      check("mrst_we", {31'd0, bus.ms_rf_we}, 32'd0);
      check("mrst_waddr", {27'd0, bus.ms_rf_waddr}, 32'd0);
      check("mrst_wdata", bus.ms_rf_wdata, 32'd0);
      check("mrst_resmem", {31'd0, bus.ms_res_from_mem}, 32'd0);
      check("mrst_allowin", {31'd0, bus.ms_allowin}, 32'd1);
      check("mrst_pc", bus.ms_pc, 32'd0);
      resetn = 1'b1;
      bus.ws_allowin = 1'b1;
      issue(LD_W, 1'b1, 1'b1, 32'h600, 32'h0, 5'd9);
      step();
      bus.es_to_ms_valid  = 1'b0;
      bus.data_sram_rdata = 32'h1234_5678;
      #1;
      check("post_rst_wdata", bus.ms_rf_wdata, 32'h1234_5678);
      step();

`ifdef MEM_ALE_CHECK_EN
      issue(LD_W, 1'b1, 1'b1, 32'h700, 32'h2, 5'd10);
      step();
      bus.es_to_ms_valid  = 1'b0;
      #1;
      check("ale_ldw_flag", {31'd0, bus.ms_ale}, 32'd1);
      check("ale_ldw_we", {31'd0, bus.ms_rf_we}, 32'd0);
      issue(LD_HU, 1'b1, 1'b1, 32'h704, 32'h4, 5'd11);
      step();
      bus.es_to_ms_valid  = 1'b0;
      #1;
      check("ale_ok_flag", {31'd0, bus.ms_ale}, 32'd0);
      check("ale_ok_we", {31'd0, bus.ms_rf_we}, 32'd1);
      step();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
